// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the round sequencer state encoding.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;
    localparam int RND_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer over an external single-round datapath: initial AddRoundKey, then NR launch/capture passes.
// Each round costs 1 launch cycle + datapath latency + 1 capture cycle; the result is held on out_* until out_ready.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLK_W,
    parameter int NR     = AES_NR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [RND_W-1:0]  rk_idx,
    input  logic [DATA_W-1:0] rk_data,
    output logic              rnd_valid,
    output logic [DATA_W-1:0] rnd_data,
    output logic              rnd_final,
    output logic [DATA_W-1:0] rnd_key,
    input  logic              rnd_done,
    input  logic [DATA_W-1:0] rnd_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

    ctrl_state_e       state_q, state_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic [DATA_W-1:0] blk_q, blk_d;
    logic [DATA_W-1:0] rnd_data_q, rnd_data_d;
    logic [DATA_W-1:0] rnd_key_q, rnd_key_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic              rnd_final_q, rnd_final_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            blk_q       <= '0;
            rnd_data_q  <= '0;
            rnd_key_q   <= '0;
            out_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            rnd_final_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            rnd_data_q  <= rnd_data_d;
            rnd_key_q   <= rnd_key_d;
            out_data_q  <= out_data_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_final_q <= rnd_final_d;
        end
    end

    // rnd_valid/rnd_final are one-cycle pulses; rnd_done outside WAIT falls through untouched.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        blk_d       = blk_q;
        rnd_data_d  = rnd_data_q;
        rnd_key_d   = rnd_key_q;
        out_data_d  = out_data_q;
        rnd_valid_d = 1'b0;
        rnd_final_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    blk_d   = in_data ^ rk_data;
                    round_d = RND_W'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                rnd_data_d  = blk_q;
                rnd_key_d   = rk_data;
                rnd_final_d = (round_q == LAST_RND);
                rnd_valid_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (rnd_done) begin
                    blk_d = rnd_result;
                    if (round_q == LAST_RND) begin
                        out_data_d = rnd_result;
                        state_d    = ST_DONE;
                    end else begin
                        round_d = round_q + RND_W'(1);
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign rk_idx    = (state_q == ST_IDLE) ? '0 : round_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_final = rnd_final_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_key   = rnd_key_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round datapath and key schedule around the controller.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR = 10;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         rnd_valid;
    logic [127:0] rnd_data;
    logic         rnd_final;
    logic [127:0] rnd_key;
    logic         rnd_done;
    logic [127:0] rnd_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_final (rnd_final),
        .rnd_key   (rnd_key),
        .rnd_done  (rnd_done),
        .rnd_result(rnd_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int pulse_cnt = 0;
    logic [3:0] prev_rk = '0;
    bit rand_lat = 1'b0;

    logic [7:0]   sbox [0:255];
    logic [127:0] rk_tab [0:10];
    logic         mdl_done = 1'b0;
    logic         spur_done = 1'b0;
    logic [127:0] mdl_res = '0;
    logic [127:0] spur_res = '0;
    logic [127:0] mdl_tmp;
    int           mdl_lat;

    assign rk_data    = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;
    assign rnd_done   = mdl_done | spur_done;
    assign rnd_result = mdl_done ? mdl_res : spur_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    // Byte i of a block is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                                input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i] ^ k[127-8*i -: 8];
        return o;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Round datapath: result appears L cycles after the rnd_valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_valid) begin
                mdl_tmp = aes_round(rnd_data, rnd_key, rnd_final);
                mdl_lat = rand_lat ? int'($urandom_range(1, 8)) : 3;
                repeat (mdl_lat) @(negedge clk);
                mdl_res  = mdl_tmp;
                mdl_done = 1'b1;
                @(negedge clk);
                mdl_done = 1'b0;
            end
        end
    end

    // Launch monitor: final flag, key and the index requested in the LAUNCH cycle.
    always @(negedge clk) begin
        if (rnd_valid) begin
            pulse_cnt++;
            if (pulse_cnt <= NR) begin
                chk("rnd_final", rnd_final, pulse_cnt == NR);
                chk("rnd_key", rnd_key, rk_tab[pulse_cnt]);
                chk("rk_idx_launch", prev_rk, pulse_cnt);
            end else begin
                chk("extra_launch", pulse_cnt, NR);
            end
        end
        prev_rk = rk_idx;
    end

    task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
        int k;
        expand(key);
        pulse_cnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pt;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_accept", in_ready, 1);
        chk("rk_idx_idle", rk_idx, 0);
        @(posedge clk);
        #1;
        acc = cyc;
        chk("busy_accept", busy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 128'hdeadbeef_0badf00d_cafef00d_12345678;
    endtask

    task automatic wait_out(output int n);
        int k;
        k = 0;
        while (!out_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n = cyc;
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic finish_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_rise", in_ready, 1);
        chk("busy_clear", busy, 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        bit           rl;
        int           bp;
    } vec_t;

    vec_t vt [4];

    initial begin
        int  n, k;
        bit  ok;
        vt[0] = '{pt: PT_C1,  key: K_C1,  ct: CT_C1, rl: 1'b0, bp: 0};
        vt[1] = '{pt: PT_C1,  key: K_C1,  ct: CT_C1, rl: 1'b1, bp: 20};
        vt[2] = '{pt: '0,     key: '0,    ct: CT_Z,  rl: 1'b0, bp: 3};
        vt[3] = '{pt: PT_B,   key: K_B,   ct: CT_B,  rl: 1'b1, bp: 0};
        build_sbox();
        expand(K_C1);

        #1 reset = 1'b0;
        #2;
        chk("rst_rnd_valid", rnd_valid, 0);
        chk("rst_rnd_final", rnd_final, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_rnd_data", rnd_data, 0);
        chk("rst_rnd_key", rnd_key, 0);
        chk("rst_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // spurious datapath result while idle
        spur_done = 1'b1;
        spur_res  = {4{$urandom}};
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_in_ready", in_ready, 1);
        chk("spur_idle_out_valid", out_valid, 0);
        chk("spur_idle_launch", pulse_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            rand_lat = vt[v].rl;
            start_block(vt[v].pt, vt[v].key);
            wait_out(n);
            chk("ciphertext", out_data, vt[v].ct);
            chk("launch_count", pulse_cnt, NR);
            if (!vt[v].rl) chk("accept_to_out_valid", n - acc + 1, 1 + NR * (1 + 3 + 1));
            if (vt[v].bp > 0) begin
                ok = 1'b1;
                repeat (vt[v].bp) begin
                    @(negedge clk);
                    if (!out_valid || out_data !== vt[v].ct || in_ready || !busy) ok = 1'b0;
                end
                chk("backpressure_hold", ok, 1);
            end
            finish_out();
        end

        // in_valid during WAIT, then spurious rnd_done in DONE
        rand_lat = 1'b0;
        start_block(PT_C1, K_C1);
        k = 0;
        while (pulse_cnt < 3 && k < 500) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        in_data  = '1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (in_ready) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("in_ready_low_wait", ok, 1);
        wait_out(n);
        chk("ct_after_in_valid", out_data, CT_C1);
        @(negedge clk);
        spur_done = 1'b1;
        spur_res  = {4{$urandom}};
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        chk("spur_done_out_data", out_data, CT_C1);
        chk("spur_done_out_valid", out_valid, 1);
        chk("spur_done_launch", pulse_cnt, NR);
        finish_out();

        // reset pulse while round 5 is in flight
        start_block(PT_C1, K_C1);
        k = 0;
        while (pulse_cnt < 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        #2 reset = 1'b0;
        #1;
        chk("abort_rnd_valid", rnd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rk_idx", rk_idx, 0);
        chk("abort_rnd_data", rnd_data, 0);
        chk("abort_rnd_key", rnd_key, 0);
        chk("abort_out_data", out_data, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("late_done_busy", busy, 0);
        chk("late_done_out_valid", out_valid, 0);
        chk("late_done_launch", pulse_cnt, 5);
        chk("late_done_in_ready", in_ready, 1);
        start_block(PT_C1, K_C1);
        wait_out(n);
        chk("ct_after_abort", out_data, CT_C1);
        finish_out();

        // back-to-back blocks with out_ready held high
        out_ready = 1'b1;
        start_block(PT_C1, K_C1);
        wait_out(n);
        chk("b2b_ct1", out_data, CT_C1);
        expand('0);
        pulse_cnt = 0;
        in_valid  = 1'b1;
        in_data   = '0;
        @(posedge clk);
        #1;
        chk("b2b_handshake_in_ready", in_ready, 1);
        chk("b2b_handshake_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        acc = cyc;
        chk("b2b_accept_next", busy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        chk("b2b_ct2", out_data, CT_Z);
        chk("b2b_launch_count", pulse_cnt, NR);
        chk("b2b_latency", n - acc + 1, 1 + NR * (1 + 3 + 1));
        @(posedge clk);
        #1;
        chk("b2b_final_drop", out_valid, 0);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative sequencer for AES-128 encryption over one shared single-round datapath (SubBytes→ShiftRows→MixColumns→AddRoundKey chain, each stage with valid_in/valid_out, active-low async reset).
- Accepts one 128-bit block, performs the initial AddRoundKey, then issues 10 round passes through the external round datapath, tracking the round number and requesting round keys.
- Presents the ciphertext on a valid/ready output port. Sits between the host interface and the round pipeline/key schedule.

Parameters:
- DATA_W, 128, block and round-key width
- NR, 10, number of rounds (4-bit counter, NR ≤ 15)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext offered
- in_ready  output  1  controller idle and able to accept
- in_data  input  DATA_W  plaintext block
- rk_idx  output  4  round-key index requested from key schedule (0..NR)
- rk_data  input  DATA_W  round key for rk_idx, combinational/stable same cycle
- rnd_valid  output  1  one-cycle launch pulse into round datapath
- rnd_data  output  DATA_W  state launched into round datapath
- rnd_final  output  1  high with rnd_valid on round NR; datapath bypasses MixColumns
- rnd_key  output  DATA_W  round key accompanying launch (registered copy of rk_data)
- rnd_done  input  1  round datapath result valid (single-cycle pulse)
- rnd_result  input  DATA_W  round datapath result
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  ciphertext
- busy  output  1  high from accept until output handshake completes

Behaviour:
- Reset (async, reset=0): state IDLE, round counter 0, state register 0; in_ready=1 after reset release, rnd_valid=0, rnd_final=0, out_valid=0, busy=0, rk_idx=0, rnd_data/rnd_key/out_data=0.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE: in_ready=1, rk_idx=0. On in_valid&in_ready: state_reg ← in_data XOR rk_data (initial AddRoundKey), round ← 1, go LAUNCH.
- LAUNCH (one cycle): rk_idx=round. Registers rnd_data←state_reg, rnd_key←rk_data, rnd_final←(round==NR), rnd_valid←1 for exactly one cycle. Go WAIT.
- WAIT: rnd_valid=0; hold until rnd_done. On rnd_done: state_reg ← rnd_result. If round==NR, out_data ← rnd_result and go DONE; else round ← round+1 and go LAUNCH.
- Round period = 1 launch cycle + datapath latency + 1 capture cycle; the controller places no assumption on datapath latency.
- DONE: out_valid=1, out_data stable. Hold until out_ready. On out_valid&out_ready go IDLE; out_valid drops the next cycle; in_ready rises the same cycle.
- in_ready is 0 in LAUNCH/WAIT/DONE; in_valid is ignored there; the block is never overwritten.
- rnd_done while in IDLE/LAUNCH/DONE: spurious, ignored, no state change.
- out_ready high before out_valid: no effect.
- busy = (state != IDLE).
- Reset asserted mid-operation: immediate abort to reset values; no partial output; any in-flight datapath result after release is ignored (arrives in IDLE).
- Minimum accept-to-out_valid with 3-cycle datapath: 1 + NR·(1+3+1) = 51 cycles.

Decomposition:
- Shared package aes_pkg: AES_BLK_W=128, AES_NR=10, FSM state encoding localparams (IDLE/LAUNCH/WAIT/DONE), round-index width 4.
- No sub-module needed. The 4-bit round counter and FSM are inline; the round datapath and key schedule stay external.

Test Plan:
- FIPS-197 C.1: in_data=00112233445566778899aabbccddeeff, key 000102…0f, bench behavioural round model with 3-cycle latency → out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 51 after accept, rnd_valid pulses=10, rnd_final only on 10th pulse.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_valid/out_data held, in_ready=0; then out_ready=1 → IDLE, next block accepted the following cycle.
- Variable latency: datapath latency randomized 1..8 per round on the C.1 vector → same ciphertext; rk_idx sequence 0,1,…,10.
- Spurious rnd_done in IDLE and DONE, plus in_valid during WAIT → no state change, no extra launches, result unaffected.
- Reset pulse mid-round 5 → all outputs return to reset values asynchronously; a late rnd_done after release is ignored; a fresh C.1 block then completes correctly.
- Back-to-back: two blocks (C.1 and all-zero plaintext/all-zero key → 66e94bd4ef8a2c3b884cfa59ca342b2e) with out_ready=1 → both correct, in order, no lost handshake.
